// File: rtl/sy_pkg.sv
// Shared fetch-side types and helpers: the instruction-buffer lane record and
// the RVC detector used by the realigner, the fetch path and the decompressor.
package sy_pkg;

  // Number of instruction lanes pushed into the instruction buffer per cycle.
  localparam int unsigned INSTR_PER_FETCH = 2;

  // One instruction-buffer lane as produced by the realigner.
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] instr;
  } lane_t;

  // A halfword starts a compressed instruction unless its low two bits are 11.
  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/sy_ppl_instr_realign.sv
// Fetch realigner: splits 32-bit halfword-addressed fetch blocks into up to two
// aligned RVC/RV64 instructions. It carries the lower half of a 32-bit
// instruction that straddles two blocks, and registers the lanes in one
// output stage that feeds the instruction buffer.
module sy_ppl_instr_realign
  import sy_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          fet_valid_i,
  input  logic [63:0]                   fet_vaddr_i,
  input  logic [31:0]                   fet_data_i,
  input  logic                          fet_ex_i,
  output logic                          fet_ready_o,
  input  logic                          ibuf_ready_i,
  output logic [INSTR_PER_FETCH-1:0]    ibuf_valid_o,
  output logic [INSTR_PER_FETCH*64-1:0] ibuf_pc_o,
  output logic [INSTR_PER_FETCH*64-1:0] ibuf_npc_o,
  output logic [INSTR_PER_FETCH*32-1:0] ibuf_instr_o,
  output logic                          ibuf_ex_o
);

  // Carry state: lower halfword of a straddling 32-bit instruction and its pc.
  logic        carry_v_r;
  logic [15:0] carry_instr_r;
  logic [63:0] carry_pc_r;

  // Output stage.
  logic                             out_v_r;
  logic                             out_ex_r;
  lane_t [INSTR_PER_FETCH-1:0]      out_lane_r;

  // Realign results for the block currently presented.
  lane_t [INSTR_PER_FETCH-1:0]      lane_n_s;
  logic                             ex_n_s;
  logic                             carry_set_s;
  logic [15:0]                      carry_instr_n_s;
  logic [63:0]                      carry_pc_n_s;

  logic        accept_s;
  logic        carry_usable_s;
  logic [15:0] lo_s;
  logic [15:0] hi_s;
  logic [63:0] hi_pc_s;

  assign fet_ready_o    = ~out_v_r | ibuf_ready_i;
  assign accept_s       = fet_valid_i & fet_ready_o;
  assign lo_s           = fet_data_i[15:0];
  assign hi_s           = fet_data_i[31:16];
  // The upper halfword always lives at the block base with bit1 set.
  assign hi_pc_s        = {fet_vaddr_i[63:2], 2'b10};
  // The carry only continues if this block is the very next halfword after it.
  assign carry_usable_s = carry_v_r & (fet_vaddr_i == (carry_pc_r + 64'd2));

  // Split the presented block into lanes and decide the next carry contents.
  always_comb begin
    lane_n_s        = '0;
    ex_n_s          = 1'b0;
    carry_set_s     = 1'b0;
    carry_instr_n_s = 16'h0000;
    carry_pc_n_s    = 64'd0;
    if (fet_ex_i) begin
      // Faulting block: lane 0 carries the fault with a zero instruction, data ignored.
      lane_n_s[0].valid = 1'b1;
      lane_n_s[0].pc    = fet_vaddr_i;
      lane_n_s[0].npc   = fet_vaddr_i + 64'd4;
      lane_n_s[0].instr = 32'h0000_0000;
      ex_n_s            = 1'b1;
    end else if (carry_usable_s) begin
      // Complete the straddling instruction, then treat the upper halfword.
      lane_n_s[0].valid = 1'b1;
      lane_n_s[0].pc    = carry_pc_r;
      lane_n_s[0].npc   = carry_pc_r + 64'd4;
      lane_n_s[0].instr = {lo_s, carry_instr_r};
      if (is_compressed(hi_s)) begin
        lane_n_s[1].valid = 1'b1;
        lane_n_s[1].pc    = hi_pc_s;
        lane_n_s[1].npc   = hi_pc_s + 64'd2;
        lane_n_s[1].instr = {16'h0000, hi_s};
      end else begin
        carry_set_s     = 1'b1;
        carry_instr_n_s = hi_s;
        carry_pc_n_s    = hi_pc_s;
      end
    end else if (!fet_vaddr_i[1]) begin
      lane_n_s[0].valid = 1'b1;
      lane_n_s[0].pc    = fet_vaddr_i;
      if (!is_compressed(lo_s)) begin
        lane_n_s[0].npc   = fet_vaddr_i + 64'd4;
        lane_n_s[0].instr = fet_data_i;
      end else begin
        lane_n_s[0].npc   = fet_vaddr_i + 64'd2;
        lane_n_s[0].instr = {16'h0000, lo_s};
        if (is_compressed(hi_s)) begin
          lane_n_s[1].valid = 1'b1;
          lane_n_s[1].pc    = hi_pc_s;
          lane_n_s[1].npc   = hi_pc_s + 64'd2;
          lane_n_s[1].instr = {16'h0000, hi_s};
        end else begin
          carry_set_s     = 1'b1;
          carry_instr_n_s = hi_s;
          carry_pc_n_s    = hi_pc_s;
        end
      end
    end else begin
      // Entry at the upper half (jump target): only hi is considered.
      if (is_compressed(hi_s)) begin
        lane_n_s[0].valid = 1'b1;
        lane_n_s[0].pc    = fet_vaddr_i;
        lane_n_s[0].npc   = fet_vaddr_i + 64'd2;
        lane_n_s[0].instr = {16'h0000, hi_s};
      end else begin
        carry_set_s     = 1'b1;
        carry_instr_n_s = hi_s;
        carry_pc_n_s    = fet_vaddr_i;
      end
    end
  end

  // Carry register: updates only when a block is accepted; flush drops it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carry_v_r     <= 1'b0;
      carry_instr_r <= 16'h0000;
      carry_pc_r    <= 64'd0;
    end else if (flush_i) begin
      carry_v_r     <= 1'b0;
    end else if (accept_s) begin
      carry_v_r     <= carry_set_s;
      carry_instr_r <= carry_instr_n_s;
      carry_pc_r    <= carry_pc_n_s;
    end else begin
      carry_v_r     <= carry_v_r;
    end
  end

  // Output stage: load on accept, drain when the buffer takes it, hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_v_r    <= 1'b0;
      out_ex_r   <= 1'b0;
      out_lane_r <= '0;
    end else if (flush_i) begin
      out_v_r             <= 1'b0;
      out_ex_r            <= 1'b0;
      out_lane_r[0].valid <= 1'b0;
      out_lane_r[1].valid <= 1'b0;
    end else if (accept_s) begin
      out_v_r    <= 1'b1;
      out_ex_r   <= ex_n_s;
      out_lane_r <= lane_n_s;
    end else if (ibuf_ready_i) begin
      out_v_r    <= 1'b0;
    end else begin
      out_v_r    <= out_v_r;
    end
  end

  // Drive the flat lane ports; valid and fault are masked while flushing.
  always_comb begin
    ibuf_valid_o = {INSTR_PER_FETCH{1'b0}};
    ibuf_ex_o    = 1'b0;
    if (out_v_r && !flush_i) begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        ibuf_valid_o[i] = out_lane_r[i].valid;
      end
      ibuf_ex_o = out_ex_r;
    end else begin
      ibuf_valid_o = {INSTR_PER_FETCH{1'b0}};
      ibuf_ex_o    = 1'b0;
    end
    for (int i = 0; i < INSTR_PER_FETCH; i++) begin
      ibuf_pc_o[i*64 +: 64]    = out_lane_r[i].pc;
      ibuf_npc_o[i*64 +: 64]   = out_lane_r[i].npc;
      ibuf_instr_o[i*32 +: 32] = out_lane_r[i].instr;
    end
  end

endmodule

// File: tb/tb_sy_ppl_instr_realign.sv
// Directed bench for sy_ppl_instr_realign with hand-computed expectations.
module tb_sy_ppl_instr_realign;

  logic         clk_i;
  logic         rst_i;
  logic         flush_i;
  logic         fet_valid_i;
  logic [63:0]  fet_vaddr_i;
  logic [31:0]  fet_data_i;
  logic         fet_ex_i;
  logic         fet_ready_o;
  logic         ibuf_ready_i;
  logic [1:0]   ibuf_valid_o;
  logic [127:0] ibuf_pc_o;
  logic [127:0] ibuf_npc_o;
  logic [63:0]  ibuf_instr_o;
  logic         ibuf_ex_o;

  int checks = 0;
  int errors = 0;

  sy_ppl_instr_realign dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .fet_valid_i  (fet_valid_i),
    .fet_vaddr_i  (fet_vaddr_i),
    .fet_data_i   (fet_data_i),
    .fet_ex_i     (fet_ex_i),
    .fet_ready_o  (fet_ready_o),
    .ibuf_ready_i (ibuf_ready_i),
    .ibuf_valid_o (ibuf_valid_o),
    .ibuf_pc_o    (ibuf_pc_o),
    .ibuf_npc_o   (ibuf_npc_o),
    .ibuf_instr_o (ibuf_instr_o),
    .ibuf_ex_o    (ibuf_ex_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane0(input string tag, input logic [1:0] v, input logic [63:0] pc,
                           input logic [63:0] npc, input logic [31:0] ins, input logic ex);
    chk({tag, ".valid"}, {62'd0, ibuf_valid_o}, {62'd0, v});
    chk({tag, ".pc0"},   ibuf_pc_o[63:0], pc);
    chk({tag, ".npc0"},  ibuf_npc_o[63:0], npc);
    chk({tag, ".ins0"},  {32'd0, ibuf_instr_o[31:0]}, {32'd0, ins});
    chk({tag, ".ex"},    {63'd0, ibuf_ex_o}, {63'd0, ex});
  endtask

  task automatic chk_lane1(input string tag, input logic [63:0] pc,
                           input logic [63:0] npc, input logic [31:0] ins);
    chk({tag, ".pc1"},  ibuf_pc_o[127:64], pc);
    chk({tag, ".npc1"}, ibuf_npc_o[127:64], npc);
    chk({tag, ".ins1"}, {32'd0, ibuf_instr_o[63:32]}, {32'd0, ins});
  endtask

  // Present one block for a single edge; caller guarantees fet_ready_o is high.
  task automatic send(input logic [63:0] a, input logic [31:0] d, input logic ex);
    fet_valid_i = 1'b1;
    fet_vaddr_i = a;
    fet_data_i  = d;
    fet_ex_i    = ex;
    @(posedge clk_i); #1;
    fet_valid_i = 1'b0;
    fet_ex_i    = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    fet_valid_i  = 1'b0;
    fet_vaddr_i  = 64'd0;
    fet_data_i   = 32'd0;
    fet_ex_i     = 1'b0;
    ibuf_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;

    // Reset state.
    chk("rst.ready", {63'd0, fet_ready_o}, 64'd1);
    chk_lane0("rst", 2'b00, 64'd0, 64'd0, 32'd0, 1'b0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Aligned 32-bit instruction.
    send(64'h1000, 32'h4501_00B3, 1'b0);
    chk_lane0("aligned", 2'b01, 64'h1000, 64'h1004, 32'h4501_00B3, 1'b0);

    // Two compressed instructions.
    send(64'h2000, 32'h4505_4501, 1'b0);
    chk_lane0("two_rvc", 2'b11, 64'h2000, 64'h2002, 32'h0000_4501, 1'b0);
    chk_lane1("two_rvc", 64'h2002, 64'h2004, 32'h0000_4505);

    // Straddling instruction across two blocks.
    send(64'h3000, 32'h00B3_4501, 1'b0);
    chk_lane0("strad_a", 2'b01, 64'h3000, 64'h3002, 32'h0000_4501, 1'b0);
    send(64'h3004, 32'h4505_0001, 1'b0);
    chk_lane0("strad_b", 2'b11, 64'h3002, 64'h3006, 32'h0001_00B3, 1'b0);
    chk_lane1("strad_b", 64'h3006, 64'h3008, 32'h0000_4505);

    // Unaligned entry at the upper half.
    send(64'h4002, 32'h4505_ABCD, 1'b0);
    chk_lane0("unalign", 2'b01, 64'h4002, 64'h4004, 32'h0000_4505, 1'b0);

    // Address wrap at the top of the address space.
    send(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 1'b0);
    chk_lane0("wrap", 2'b01, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 32'h0000_0013, 1'b0);

    // Zero-instruction block leaves a carry, then a non-contiguous block discards it.
    send(64'h7002, 32'h00B3_0000, 1'b0);
    chk_lane0("zero_inst", 2'b00, 64'd0, 64'd0, 32'd0, 1'b0);
    chk("zero_inst.ready", {63'd0, fet_ready_o}, 64'd1);
    send(64'h1000, 32'h4505_4501, 1'b0);
    chk_lane0("stale_carry", 2'b11, 64'h1000, 64'h1002, 32'h0000_4501, 1'b0);

    // Backpressure: outputs hold and input stalls for 3 cycles.
    @(posedge clk_i); #1;
    ibuf_ready_i = 1'b0;
    send(64'h2000, 32'h4505_4501, 1'b0);
    fet_valid_i = 1'b1;
    fet_vaddr_i = 64'h8000;
    fet_data_i  = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      chk("bp.ready", {63'd0, fet_ready_o}, 64'd0);
      chk_lane0("bp.hold", 2'b11, 64'h2000, 64'h2002, 32'h0000_4501, 1'b0);
      @(posedge clk_i); #1;
    end
    ibuf_ready_i = 1'b1;
    #1;
    chk("bp.release", {63'd0, fet_ready_o}, 64'd1);
    @(posedge clk_i); #1;
    fet_valid_i = 1'b0;
    chk_lane0("bp.next", 2'b01, 64'h8000, 64'h8004, 32'h0000_0013, 1'b0);

    // Flush with a carry pending; the block in the flush cycle is dropped.
    send(64'h5000, 32'h00B3_4501, 1'b0);
    chk_lane0("fl.pre", 2'b01, 64'h5000, 64'h5002, 32'h0000_4501, 1'b0);
    flush_i     = 1'b1;
    fet_valid_i = 1'b1;
    fet_vaddr_i = 64'h9000;
    fet_data_i  = 32'h0000_0013;
    #1;
    chk("fl.valid_comb", {62'd0, ibuf_valid_o}, 64'd0);
    @(posedge clk_i); #1;
    flush_i     = 1'b0;
    fet_valid_i = 1'b0;
    chk("fl.dropped", {62'd0, ibuf_valid_o}, 64'd0);
    send(64'h5004, 32'h4505_0001, 1'b0);
    chk_lane0("fl.post", 2'b11, 64'h5004, 64'h5006, 32'h0000_0001, 1'b0);
    chk_lane1("fl.post", 64'h5006, 64'h5008, 32'h0000_4505);

    // Page fault with a usable carry pending clears the carry.
    send(64'h5FFC, 32'h00B3_4501, 1'b0);
    chk_lane0("ex.pre", 2'b01, 64'h5FFC, 64'h5FFE, 32'h0000_4501, 1'b0);
    send(64'h6000, 32'h4505_0001, 1'b1);
    chk_lane0("ex", 2'b01, 64'h6000, 64'h6004, 32'h0000_0000, 1'b1);
    send(64'h6000, 32'h4505_0001, 1'b0);
    chk_lane0("ex.post", 2'b11, 64'h6000, 64'h6002, 32'h0000_0001, 1'b0);

    // Drain: with no new block the output stage empties.
    @(posedge clk_i); #1;
    chk("drain.valid", {62'd0, ibuf_valid_o}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
